dequantization_ctrl: RTL and testbench
======================================

Name: dequantization_ctrl

Overview:
- Decoder-side counterpart of the encoder quantization stage.
- Accepts one 8x8 block of quantized coefficients in zig-zag order from the run-length/entropy decoder.
- Multiplies each coefficient by its quantization step from the table ROM, then writes the result in natural (raster) order into the IDCT input buffer.
- If the block ends early (end-of-block), it writes zeros to all remaining positions, so the IDCT always receives 64 writes per block.

Parameters:
- COEF_W, 12, signed quantized coefficient width
- Q_W, 8, unsigned quantization step width
- OUT_W, 16, signed dequantized output width (saturating)

Ports:
- clk_in  input  1  clock
- rst  input  1  synchronous active-high reset
- valid_d_in  input  1  coefficient valid; accepted only when in_ready=1
- d_in  input  COEF_W  signed quantized coefficient, zig-zag order
- eob_in  input  1  qualifies the accepted coefficient as the last nonzero one of the block
- eof_in  input  1  qualifies the accepted coefficient as belonging to the last block of the frame
- factor_sel  input  2  quality table select
- quan_rom_in  input  Q_W  quantization step, valid 1 cycle after rom_rd
- zig_zag_rom_in  input  6  natural index for the zig-zag index on rom_addr[5:0], valid 1 cycle after rom_rd
- in_ready  output  1  block can accept a coefficient
- rom_rd  output  1  ROM read strobe
- rom_addr  output  9  {factor_sel, ycbcr[1], zz_idx[5:0]}
- d_out  output  OUT_W  dequantized coefficient
- wr_addr  output  6  natural-order IDCT buffer address
- wr_en  output  1  IDCT buffer write strobe
- block_done  output  1  1-cycle pulse with the 64th write of a block
- eof_out  output  1  1-cycle pulse together with block_done of the eof block

Behaviour:
- Reset (synchronous, active-high): state=DQ_IDLE, zz_idx=0, ycbcr=2'b01, eob_l=0, eof_l=0.
  - Registered outputs cleared: d_out=0, wr_addr=0, wr_en=0, block_done=0, eof_out=0.
  - in_ready and rom_rd are forced to 0 while rst=1.
- Any in-progress block is discarded on reset; no further writes occur for it.
- in_ready = (state==DQ_IDLE). No backpressure exists from the IDCT side.

FSM:
- DQ_IDLE
  - On valid_d_in: latch d_in, eob_in and eof_in; assert rom_rd (combinational) with rom_addr at the current zz_idx; go to DQ_WAIT.
- DQ_WAIT
  - Capture quan_rom_in into q and zig_zag_rom_in into nat_idx; go to DQ_CALC.
- DQ_CALC
  - Register d_out=sat(coef*q), wr_addr=nat_idx, wr_en=1.
  - If zz_idx==63: block end. Otherwise zz_idx+1, then go to DQ_FILL_RD if eob_l=1, else DQ_IDLE.
- DQ_FILL_RD
  - Assert rom_rd at the current zz_idx; go to DQ_FILL_WR.
- DQ_FILL_WR
  - Register d_out=0, wr_addr=zig_zag_rom_in, wr_en=1.
  - If zz_idx==63: block end. Otherwise zz_idx+1 and return to DQ_FILL_RD.

Block end:
- block_done=1, zz_idx wraps to 0, eob_l cleared, go to DQ_IDLE.
- ycbcr advances 01→10→11→01.
- If eof_l=1: eof_out=1, ycbcr forced to 01, eof_l cleared.

Timing and arithmetic:
- Latency: coefficient accepted at cycle T → wr_en high at T+3. Throughput is 1 coefficient per 3 cycles; zero-fill runs at 1 write per 2 cycles.
- Product is signed COEF_W × unsigned Q_W (zero-extended), a 20-bit signed result. It is saturated to [-32768, 32767], with no rounding.
- wr_en, block_done and eof_out are single-cycle pulses.

Boundary and corner cases:
- eob_in on the coefficient at zz_idx=63: no fill.
- eob_in on the coefficient at zz=0: 63 fill writes follow.
- valid_d_in while in_ready=0: ignored, and the coefficient is not accepted.
- eof_in without eob_in: honoured at the natural block end.
- q=0 → d_out=0.

Decomposition:
- Shared package jpeg_dec_pkg holds:
  - state encodings DQ_IDLE, DQ_WAIT, DQ_CALC, DQ_FILL_RD, DQ_FILL_WR (3 bits);
  - component codes COMP_Y=2'b01, COMP_CB=2'b10, COMP_CR=2'b11;
  - BLK_LAST=6'd63.
- One sub-module, dequant_mult_sat: combinational signed×unsigned multiply with saturation to OUT_W.

Test Plan:
- Full block of 64 coefficients d_in=1, flat ROM q=2, identity zig-zag ROM → 64 writes of d_out=2 at wr_addr 0..63; block_done on the 64th; each wr_en exactly 3 cycles after acceptance.
- d_in=-5 at zz=0 with eob_in=1, q=16 → write d_out=-80 at wr_addr=zig_zag_rom(0), then 63 zero writes at 2-cycle spacing covering every remaining natural index exactly once; block_done on the last.
- d_in=2047 with q=255 → d_out=32767; d_in=-2048 with q=255 → d_out=-32768.
- Three consecutive blocks, factor_sel=2 → rom_addr[8:6] = 3'b100, 3'b101, 3'b101 for Y, Cb, Cr; 4th block returns to 3'b100. eof_in on the 3rd block → eof_out coincides with its block_done.
- Assert valid_d_in continuously → only one acceptance per 3 cycles; in_ready low in WAIT/CALC/FILL states.
- Reset asserted mid-fill at zz=30 → next cycle all outputs at reset values. A new block then starts at zz=0 with ycbcr=01, and no stale writes appear.

Source files
------------

// File: rtl/jpeg_dec_pkg.sv
// Shared definitions for the JPEG decoder datapath: dequantizer FSM states,
// colour component codes and block geometry.
package jpeg_dec_pkg;

    typedef enum logic [2:0] {
        DQ_IDLE    = 3'd0,
        DQ_WAIT    = 3'd1,
        DQ_CALC    = 3'd2,
        DQ_FILL_RD = 3'd3,
        DQ_FILL_WR = 3'd4
    } dq_state_e;

    localparam logic [1:0] COMP_Y  = 2'b01;
    localparam logic [1:0] COMP_CB = 2'b10;
    localparam logic [1:0] COMP_CR = 2'b11;

    localparam logic [5:0] BLK_LAST = 6'd63;

    // Component rotation Y -> Cb -> Cr -> Y; any unexpected code recovers to Y.
    function automatic logic [1:0] next_comp(input logic [1:0] comp);
        logic [1:0] nxt;
        case (comp)
            COMP_Y:  nxt = COMP_CB;
            COMP_CB: nxt = COMP_CR;
            default: nxt = COMP_Y;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dequant_mult_sat.sv
// Signed coefficient times unsigned quantization step, saturated to the
// signed output range. Purely combinational, no rounding.
module dequant_mult_sat #(
    parameter int COEF_W = 12,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16
) (
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic        [Q_W-1:0]    q_i,
    output logic signed [OUT_W-1:0]  res_o
);

    // One spare bit so the zero-extended step never looks negative.
    localparam int PW = COEF_W + Q_W + 1;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PW-1:0] prod_s;

    // Full-precision product followed by clamp to the output range.
    always_comb begin
        prod_s = PW'(coef_i) * PW'($signed({1'b0, q_i}));
        if (prod_s > SAT_MAX) begin
            res_o = SAT_MAX[OUT_W-1:0];
        end else if (prod_s < SAT_MIN) begin
            res_o = SAT_MIN[OUT_W-1:0];
        end else begin
            res_o = prod_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dequantization_ctrl.sv
// Dequantizer control: takes zig-zag ordered coefficients, scales each by its
// table step and writes it at its natural index into the IDCT buffer. Blocks
// cut short by end-of-block are padded with zeros so every block gets 64 writes.
module dequantization_ctrl
    import jpeg_dec_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     valid_d_in,
    input  logic signed [COEF_W-1:0] d_in,
    input  logic                     eob_in,
    input  logic                     eof_in,
    input  logic        [1:0]        factor_sel,
    input  logic        [Q_W-1:0]    quan_rom_in,
    input  logic        [5:0]        zig_zag_rom_in,
    output logic                     in_ready,
    output logic                     rom_rd,
    output logic        [8:0]        rom_addr,
    output logic signed [OUT_W-1:0]  d_out,
    output logic        [5:0]        wr_addr,
    output logic                     wr_en,
    output logic                     block_done,
    output logic                     eof_out
);

    dq_state_e                state_q;
    logic        [5:0]        zz_idx_q;
    logic        [5:0]        zz_idx_d;
    logic        [1:0]        ycbcr_q;
    logic        [1:0]        ycbcr_d;
    logic                     eob_l_q;
    logic                     eof_l_q;
    logic signed [COEF_W-1:0] coef_q;
    logic        [Q_W-1:0]    q_q;
    logic        [5:0]        nat_idx_q;
    logic signed [OUT_W-1:0]  d_out_q;
    logic        [5:0]        wr_addr_q;
    logic                     wr_en_q;
    logic                     block_done_q;
    logic                     eof_out_q;

    logic                     step_s;
    logic                     blk_end_s;
    logic signed [OUT_W-1:0]  prod_sat_s;

    dequant_mult_sat #(
        .COEF_W (COEF_W),
        .Q_W    (Q_W),
        .OUT_W  (OUT_W)
    ) u_mult (
        .coef_i (coef_q),
        .q_i    (q_q),
        .res_o  (prod_sat_s)
    );

    // Write-cycle detection and next zig-zag index / component bookkeeping.
    always_comb begin
        step_s    = (state_q == DQ_CALC) || (state_q == DQ_FILL_WR);
        blk_end_s = step_s && (zz_idx_q == BLK_LAST);

        if (blk_end_s) begin
            zz_idx_d = 6'd0;
        end else if (step_s) begin
            zz_idx_d = zz_idx_q + 6'd1;
        end else begin
            zz_idx_d = zz_idx_q;
        end

        // The last block of a frame restarts the component rotation at Y.
        if (blk_end_s) begin
            ycbcr_d = eof_l_q ? COMP_Y : next_comp(ycbcr_q);
        end else begin
            ycbcr_d = ycbcr_q;
        end
    end

    // Handshake and ROM strobe, held inactive while reset is asserted.
    always_comb begin
        in_ready = !rst && (state_q == DQ_IDLE);
        rom_rd   = !rst && (((state_q == DQ_IDLE) && valid_d_in) || (state_q == DQ_FILL_RD));
        rom_addr = {factor_sel, ycbcr_q[1], zz_idx_q};
    end

    // Main FSM with registered write-port outputs; pulses default low each cycle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= DQ_IDLE;
            zz_idx_q     <= 6'd0;
            ycbcr_q      <= COMP_Y;
            eob_l_q      <= 1'b0;
            eof_l_q      <= 1'b0;
            coef_q       <= {COEF_W{1'b0}};
            q_q          <= {Q_W{1'b0}};
            nat_idx_q    <= 6'd0;
            d_out_q      <= {OUT_W{1'b0}};
            wr_addr_q    <= 6'd0;
            wr_en_q      <= 1'b0;
            block_done_q <= 1'b0;
            eof_out_q    <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            block_done_q <= 1'b0;
            eof_out_q    <= 1'b0;
            zz_idx_q     <= zz_idx_d;
            ycbcr_q      <= ycbcr_d;

            case (state_q)
                DQ_IDLE: begin
                    if (valid_d_in) begin
                        coef_q  <= d_in;
                        eob_l_q <= eob_in;
                        eof_l_q <= eof_l_q | eof_in;
                        state_q <= DQ_WAIT;
                    end else begin
                        state_q <= DQ_IDLE;
                    end
                end

                DQ_WAIT: begin
                    q_q       <= quan_rom_in;
                    nat_idx_q <= zig_zag_rom_in;
                    state_q   <= DQ_CALC;
                end

                DQ_CALC: begin
                    d_out_q   <= prod_sat_s;
                    wr_addr_q <= nat_idx_q;
                    wr_en_q   <= 1'b1;
                    if (blk_end_s) begin
                        block_done_q <= 1'b1;
                        eof_out_q    <= eof_l_q;
                        eob_l_q      <= 1'b0;
                        eof_l_q      <= 1'b0;
                        state_q      <= DQ_IDLE;
                    end else if (eob_l_q) begin
                        state_q <= DQ_FILL_RD;
                    end else begin
                        state_q <= DQ_IDLE;
                    end
                end

                DQ_FILL_RD: begin
                    state_q <= DQ_FILL_WR;
                end

                DQ_FILL_WR: begin
                    d_out_q   <= {OUT_W{1'b0}};
                    wr_addr_q <= zig_zag_rom_in;
                    wr_en_q   <= 1'b1;
                    if (blk_end_s) begin
                        block_done_q <= 1'b1;
                        eof_out_q    <= eof_l_q;
                        eob_l_q      <= 1'b0;
                        eof_l_q      <= 1'b0;
                        state_q      <= DQ_IDLE;
                    end else begin
                        state_q <= DQ_FILL_RD;
                    end
                end

                default: begin
                    state_q <= DQ_IDLE;
                end
            endcase
        end
    end

    assign d_out      = d_out_q;
    assign wr_addr    = wr_addr_q;
    assign wr_en      = wr_en_q;
    assign block_done = block_done_q;
    assign eof_out    = eof_out_q;

endmodule

// File: tb/tb_dequantization_ctrl.sv
// Scoreboard bench for dequantization_ctrl: the driver pushes the expected
// writes of every accepted coefficient (and the zero-fill it implies), the
// monitor pops and compares on each wr_en.
module tb_dequantization_ctrl;

    localparam int COEF_W = 12;
    localparam int Q_W    = 8;
    localparam int OUT_W  = 16;

    logic                     clk_in = 1'b0;
    logic                     rst = 1'b1;
    logic                     valid_d_in = 1'b0;
    logic signed [COEF_W-1:0] d_in = '0;
    logic                     eob_in = 1'b0;
    logic                     eof_in = 1'b0;
    logic        [1:0]        factor_sel = 2'd0;
    logic        [Q_W-1:0]    quan_rom_in = '0;
    logic        [5:0]        zig_zag_rom_in = '0;
    logic                     in_ready;
    logic                     rom_rd;
    logic        [8:0]        rom_addr;
    logic signed [OUT_W-1:0]  d_out;
    logic        [5:0]        wr_addr;
    logic                     wr_en;
    logic                     block_done;
    logic                     eof_out;

    dequantization_ctrl #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .valid_d_in     (valid_d_in),
        .d_in           (d_in),
        .eob_in         (eob_in),
        .eof_in         (eof_in),
        .factor_sel     (factor_sel),
        .quan_rom_in    (quan_rom_in),
        .zig_zag_rom_in (zig_zag_rom_in),
        .in_ready       (in_ready),
        .rom_rd         (rom_rd),
        .rom_addr       (rom_addr),
        .d_out          (d_out),
        .wr_addr        (wr_addr),
        .wr_en          (wr_en),
        .block_done     (block_done),
        .eof_out        (eof_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int d;
        int a;
        bit done;
        bit eof;
        bit coef;
    } exp_t;

    exp_t        exp_q[$];
    int          lat_q[$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          model_zz = 0;
    logic [1:0]  model_comp = 2'b01;
    bit          model_eof = 1'b0;
    logic [7:0]  q_flat = 8'd2;
    int          zz_mul = 1;
    int          zz_add = 0;
    logic [63:0] seen = 64'd0;
    bit          cont_mode = 1'b0;
    int          last_acc = -1;
    bit          mon_en = 1'b0;

    always @(posedge clk_in) cyc++;

    function automatic int zz_map(input int z);
        return (z * zz_mul + zz_add) % 64;
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Table ROM model: one-cycle read latency, flat step, programmable permutation.
    always @(posedge clk_in) begin
        if (rom_rd) begin
            quan_rom_in    <= q_flat;
            zig_zag_rom_in <= 6'(zz_map(int'(rom_addr[5:0])));
        end
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic end_block();
        model_zz   = 0;
        model_comp = model_eof ? 2'b01 : ((model_comp == 2'b11) ? 2'b01 : model_comp + 2'b01);
        model_eof  = 1'b0;
    endtask

    task automatic model_accept(input int coef, input bit eob, input bit eof);
        exp_t e;
        model_eof = model_eof | eof;
        e.d    = sat16(coef * int'(q_flat));
        e.a    = zz_map(model_zz);
        e.coef = 1'b1;
        e.done = (model_zz == 63);
        e.eof  = (model_zz == 63) ? model_eof : 1'b0;
        exp_q.push_back(e);
        if (model_zz == 63) begin
            end_block();
        end else if (eob) begin
            for (int z = model_zz + 1; z < 64; z++) begin
                exp_t f;
                f.d    = 0;
                f.a    = zz_map(z);
                f.coef = 1'b0;
                f.done = (z == 63);
                f.eof  = (z == 63) ? model_eof : 1'b0;
                exp_q.push_back(f);
            end
            end_block();
        end else begin
            model_zz++;
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(wr_addr), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("d_out", $signed(d_out), e.d);
                    chk("wr_addr", 32'(wr_addr), e.a);
                    chk("block_done", 32'(block_done), 32'(e.done));
                    chk("eof_out", 32'(eof_out), 32'(e.eof));
                    if (e.coef && lat_q.size() != 0) begin
                        int a;
                        a = lat_q.pop_front();
                        chk("latency", cyc - a, 3);
                    end
                    seen[wr_addr] = 1'b1;
                    if (block_done) begin
                        chk("block_coverage", (seen == {64{1'b1}}) ? 1 : 0, 1);
                        seen = 64'd0;
                    end
                end
            end else if (block_done || eof_out) begin
                chk("stray_pulse", 32'({block_done, eof_out}), 0);
            end
        end
    end

    task automatic send(input int coef, input bit eob, input bit eof);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        d_in       = COEF_W'(coef);
        eob_in     = eob;
        eof_in     = eof;
        valid_d_in = 1'b1;
        while (!acc) begin
            @(negedge clk_in);
            if (in_ready) begin
                logic [8:0] ea;
                acc = 1'b1;
                ea  = {factor_sel, model_comp[1], 6'(model_zz)};
                chk("rom_rd_accept", 32'(rom_rd), 1);
                chk("rom_addr", 32'(rom_addr), 32'(ea));
                if (cont_mode && last_acc >= 0) begin
                    chk("accept_spacing", cyc - last_acc, 3);
                end
                last_acc = cyc;
                lat_q.push_back(cyc);
                model_accept(coef, eob, eof);
            end else begin
                n++;
                if (n > 50) begin
                    chk("accept_timeout", 0, 1);
                    break;
                end
            end
            @(posedge clk_in);
            #1;
        end
        if (!cont_mode) valid_d_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: outputs cleared, handshake forced low even with valid high.
        rst        = 1'b1;
        valid_d_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_rom_rd", 32'(rom_rd), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_d_out", $signed(d_out), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_block_done", 32'({block_done, eof_out}), 0);
        valid_d_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Full block, d=1, q=2, identity order.
        q_flat = 8'd2; zz_mul = 1; zz_add = 0;
        for (int i = 0; i < 64; i++) send(1, 1'b0, 1'b0);
        wait_drain();

        // Early EOB at zz=0 with a permuted order: -5*16 then 63 zeros.
        q_flat = 8'd16; zz_mul = 5; zz_add = 3;
        send(-5, 1'b1, 1'b0);
        wait_drain();

        // Saturation both ways, then q=0.
        q_flat = 8'd255;
        send(2047, 1'b0, 1'b0);
        send(-2048, 1'b0, 1'b0);
        q_flat = 8'd0;
        send(100, 1'b1, 1'b0);
        wait_drain();

        // Y, Cb, Cr with factor_sel=2; last block flagged end of frame.
        factor_sel = 2'd2; q_flat = 8'd7; zz_mul = 1; zz_add = 0;
        send(3, 1'b1, 1'b0);
        wait_drain();
        send(-4, 1'b1, 1'b0);
        wait_drain();
        send(5, 1'b1, 1'b1);
        wait_drain();

        // Continuous valid, full Y block, EOB on zz=63, EOF honoured at block end.
        cont_mode = 1'b1; last_acc = -1; q_flat = 8'd3; zz_mul = 5; zz_add = 7;
        for (int i = 0; i < 64; i++) send(i * 37 - 1000, (i == 63), 1'b1);
        cont_mode  = 1'b0;
        valid_d_in = 1'b0;
        wait_drain();

        // After an EOF block the component restarts at Y.
        send(9, 1'b1, 1'b0);
        wait_drain();

        // Cb block interrupted by reset in the middle of zero-fill.
        send(-5, 1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while (exp_q.size() > 34 && n < 200) begin
                @(negedge clk_in);
                #1;
                n++;
            end
        end
        chk("reset_point", exp_q.size(), 34);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_d_out", $signed(d_out), 0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        chk("mid_rst_pulses", 32'({block_done, eof_out}), 0);
        chk("mid_rst_hs", 32'({in_ready, rom_rd}), 0);
        exp_q.delete();
        lat_q.delete();
        seen       = 64'd0;
        model_zz   = 0;
        model_comp = 2'b01;
        model_eof  = 1'b0;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk_in);
        #1;

        // Fresh block starts at zz=0 as Y.
        send(6, 1'b1, 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
